// File: rtl/neuron_mac.sv
// neuron_mac: serial unsigned x*w accumulator; the scaled, saturated sum is held
// on o until the downstream threshold stage takes it.
module neuron_mac #(
   parameter int N_INPUTS = 4,
   parameter int SHIFT = 4,
   localparam int CW = $clog2(N_INPUTS + 1),
   localparam int ACC_W = 8 + CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    x,
   input  logic [3:0]    w,
   output logic [3:0]    o,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [CW-1:0] cnt
);
   typedef enum logic {ACC, OUT} state_t;
   state_t state, state_n;
   logic [ACC_W-1:0] acc, sum, s;
   logic live, accept, last;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= ACC;
      else state <= state_n;
   always_comb begin
      in_ready = (state == ACC) && live;
      o_valid = state == OUT;
      accept = in_valid && in_ready;
      last = accept && cnt == CW'(N_INPUTS - 1);
      sum = acc + ACC_W'(x) * ACC_W'(w);
      s = sum >> SHIFT;
      state_n = clr ? ACC : last ? OUT : (o_valid && o_ready) ? ACC : state;
   end
   // live keeps in_ready low until the first edge after reset is released
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc <= '0;
         cnt <= '0;
         o <= '0;
         live <= 1'b0;
      end else begin
         live <= 1'b1;
         if (clr) begin
            acc <= '0;
            cnt <= '0;
         end else if (last) begin
            acc <= '0;
            cnt <= '0;
            o <= |s[ACC_W-1:4] ? 4'hF : s[3:0];
         end else if (accept) begin
            acc <= sum;
            cnt <= cnt + CW'(1);
         end
      end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: table-driven evaluations with an expected-result queue, plus
// clr, backpressure and asynchronous reset sequences.
module tb_neuron_mac;
   logic clk = 1'b0, rst = 1'b1, clr = 1'b0, in_valid = 1'b0, o_ready = 1'b0;
   logic [3:0] x = '0, w = '0, o;
   logic in_ready, o_valid;
   logic [2:0] cnt;
   int errors = 0, checks = 0;
   logic [3:0] q[$];

   typedef struct {
      logic [15:0] xs, ws;
      bit gap, bp;
      int hold;
      logic [3:0] e;
   } vec_t;
   vec_t t[10];

   neuron_mac #(.N_INPUTS(4), .SHIFT(4)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .w(w), .o(o), .o_valid(o_valid), .o_ready(o_ready), .cnt(cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b);
      int n = 0;
      in_valid = 1'b1;
      x = a;
      w = b;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", int'(in_ready), 1);
      @(negedge clk);
   endtask

   task automatic recv(input int hold);
      int n = 0;
      logic [3:0] held;
      while (!o_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("o_valid_rise", int'(o_valid), 1);
      check("queue_nonempty", q.size(), 1);
      if (q.size() > 0) check("o", int'(o), int'(q.pop_front()));
      held = o;
      repeat (hold) begin
         @(negedge clk);
         check("o_hold", int'({o_valid, o}), int'({1'b1, held}));
      end
      o_ready = 1'b1;
      @(negedge clk);
      o_ready = 1'b0;
      check("o_valid_drop", int'(o_valid), 0);
      check("in_ready_back", int'(in_ready), 1);
   endtask

   task automatic eval(input vec_t v);
      for (int j = 0; j < 4; j++) begin
         check("cnt", int'(cnt), j);
         send(v.xs[4*j+:4], v.ws[4*j+:4]);
         if (v.gap) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
      end
      in_valid = 1'b0;
      q.push_back(v.e);
      check("in_ready_out", int'(in_ready), 0);
      check("cnt_wrap", int'(cnt), 0);
      if (v.bp) begin
         in_valid = 1'b1;
         x = 4'hF;
         w = 4'hF;
         repeat (5) begin
            @(negedge clk);
            check("bp_ready", int'(in_ready), 0);
            check("bp_cnt", int'(cnt), 0);
         end
         in_valid = 1'b0;
      end
      recv(v.hold);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      t[0] = '{16'h3333, 16'h5555, 1'b0, 1'b0, 10, 4'd3};
      t[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1, 4'hF};
      t[2] = '{16'h1111, 16'h1111, 1'b0, 1'b0, 1, 4'h0};
      t[3] = '{16'h1842, 16'hF248, 1'b1, 1'b0, 1, 4'd3};
      t[4] = '{16'hFFFF, 16'h4321, 1'b0, 1'b0, 1, 4'd9};
      t[5] = '{16'hA087, 16'hAF89, 1'b0, 1'b0, 1, 4'd14};
      t[6] = '{16'h00FF, 16'h002F, 1'b0, 1'b0, 1, 4'hF};
      t[7] = '{16'h01FF, 16'h012F, 1'b0, 1'b0, 1, 4'hF};
      t[8] = '{16'h00EF, 16'h001F, 1'b0, 1'b0, 1, 4'd14};
      t[9] = '{16'h4444, 16'h4444, 1'b0, 1'b0, 1, 4'd4};
      #1;
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_o_valid", int'(o_valid), 0);
      check("rst_o", int'(o), 0);
      check("rst_cnt", int'(cnt), 0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("in_ready_pre_edge", int'(in_ready), 0);
      @(negedge clk);
      check("in_ready_after_rst", int'(in_ready), 1);
      for (int i = 0; i < 10; i++) eval(t[i]);
      // clr after two heavy pairs; the pair presented with clr is discarded
      send(4'hF, 4'hF);
      send(4'hF, 4'hF);
      check("clr_pre_cnt", int'(cnt), 2);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      in_valid = 1'b0;
      check("clr_cnt", int'(cnt), 0);
      check("clr_o_valid", int'(o_valid), 0);
      check("clr_o_kept", int'(o), 4);
      eval(t[9]);
      // clr coinciding with the final accept suppresses the result
      for (int j = 0; j < 3; j++) send(4'hF, 4'hF);
      x = 4'hF;
      w = 4'hF;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("clr_last_o_valid", int'(o_valid), 0);
      check("clr_last_cnt", int'(cnt), 0);
      eval(t[0]);
      // asynchronous reset mid-evaluation
      send(4'hF, 4'hF);
      send(4'hF, 4'hF);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1 check("arst_cnt", int'(cnt), 0);
      check("arst_in_ready", int'(in_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      eval(t[9]);
      // asynchronous reset while a result is held
      for (int j = 0; j < 4; j++) send(4'h3, 4'h5);
      in_valid = 1'b0;
      check("arst_out_valid_pre", int'(o_valid), 1);
      check("arst_out_o_pre", int'(o), 3);
      #2 rst = 1'b1;
      #1 check("arst_out_valid", int'(o_valid), 0);
      check("arst_out_o", int'(o), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      eval(t[0]);
      check("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
